audio_recorder: RTL and testbench

- Parametrised record/playback engine for the microphone path: captures `mic_in` samples at a fixed sample rate into an on-chip buffer and replays them, one-shot or looped, on `audio_out`.
- Replaces the record-only front end. Adds variable-length takes, playback, a registered monitor pass-through and an LED progress bar.
- Sits between the audio codec interface and the output/DAC path.

---
 rtl/audio_pkg.sv | 19 +
 rtl/sample_tick_gen.sv | 25 ++
 rtl/audio_recorder.sv | 120 ++++++++++++
 tb/tb_audio_recorder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the record/playback engine.
// No logic; imported by the datapath and the rate divider.
package audio_pkg;

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

  localparam int CLK_HZ_DEF      = 50000000;
  localparam int SAMPLE_RATE_DEF = 48000;
  localparam int DIV             = CLK_HZ_DEF / SAMPLE_RATE_DEF;
  localparam int THERM_W         = 16;

  // Bits 0..n set: a bar that always shows at least one lit segment.
  function automatic logic [THERM_W-1:0] therm(input logic [3:0] n);
    logic [THERM_W-1:0] t;
    for (int i = 0; i < THERM_W; i++) t[i] = (i <= int'(n));
    return t;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every DIV cycles, first tick on the DIV-th cycle after clr.
// Combinational tick from the counter; clr restarts the count, no backpressure.
module sample_tick_gen #(
  parameter int DIV = audio_pkg::DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)       cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/audio_recorder.sv
// Record/playback engine: captures mic_in at the sample rate into a buffer, replays it one-shot or looped.
// Playback sample appears one cycle after its tick; monitor path is one registered cycle; no backpressure.
module audio_recorder
  import audio_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int SAMPLE_W    = 16,
  parameter int ADDR_W      = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] mic_in,
  input  logic                rec_key_n,
  input  logic                play_key_n,
  input  logic                loop_en,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                audio_valid,
  output logic [ADDR_W:0]     rec_len,
  output logic [17:0]         ledr
);

  localparam int TICK_DIV = CLK_HZ / SAMPLE_RATE;
  localparam logic [ADDR_W:0]   FULL_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state;
  logic [ADDR_W-1:0]   index;
  logic                rec_q, play_q;
  logic                rec_edge, play_edge;
  logic                tick, clr;
  logic                wr_en, rd_en;
  logic [SAMPLE_W-1:0] mem [2**ADDR_W];
  logic [SAMPLE_W-1:0] rd_data;
  logic [SAMPLE_W-1:0] mon_q;

  assign rec_edge  = rec_q & ~rec_key_n;
  assign play_edge = play_q & ~play_key_n;

  // Restart the divider whenever RECORD or PLAY is (re)entered.
  assign clr = (state != RECORD) &&
               (rec_edge || (play_edge && rec_len != '0));

  sample_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // A key edge in PLAY pre-empts the tick, so an aborted read never strobes.
  assign wr_en = (state == RECORD) && tick;
  assign rd_en = (state == PLAY) && tick && !rec_edge && !play_edge;

  always_ff @(posedge clk) begin
    if (wr_en) mem[index] <= mic_in;
    if (rd_en) rd_data <= mem[index];
  end

  assign audio_out = (state == PLAY || audio_valid) ? rd_data : mon_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      index       <= '0;
      rec_len     <= '0;
      audio_valid <= 1'b0;
      mon_q       <= '0;
      rec_q       <= 1'b1;
      play_q      <= 1'b1;
      ledr        <= '0;
    end else begin
      rec_q       <= rec_key_n;
      play_q      <= play_key_n;
      mon_q       <= mic_in;
      audio_valid <= rd_en;
      ledr[17]    <= (state == RECORD);
      ledr[16]    <= (state == PLAY);
      ledr[15:0]  <= (state == IDLE) ? '0 : therm(index[ADDR_W-1 -: 4]);
      case (state)
        IDLE: begin
          if (rec_edge) begin
            state <= RECORD;
            index <= '0;
          end else if (play_edge && rec_len != '0) begin
            state <= PLAY;
            index <= '0;
          end
        end
        RECORD: begin
          if (tick) index <= index + 1'b1;
          if (tick && index == LAST_ADDR) begin
            rec_len <= FULL_LEN;
            state   <= IDLE;
          end else if (rec_key_n) begin
            rec_len <= {1'b0, index} + (ADDR_W+1)'(tick);
            state   <= IDLE;
          end
        end
        PLAY: begin
          if (rec_edge) begin
            state <= RECORD;
            index <= '0;
          end else if (play_edge) begin
            index <= '0;
          end else if (tick) begin
            if ({1'b0, index} == rec_len - 1'b1) begin
              index <= '0;
              if (!loop_en) state <= IDLE;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_recorder.sv
// Randomized bench for audio_recorder: a per-cycle reference model feeds a scoreboard of playback samples.
module tb_audio_recorder;

  localparam int CLK_HZ      = 8;
  localparam int SAMPLE_RATE = 2;
  localparam int SAMPLE_W    = 16;
  localparam int ADDR_W      = 4;
  localparam int DIV         = CLK_HZ / SAMPLE_RATE;
  localparam int DEPTH       = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [SAMPLE_W-1:0] mic_in = '0;
  logic                rec_key_n = 1'b1;
  logic                play_key_n = 1'b1;
  logic                loop_en = 1'b0;
  logic [SAMPLE_W-1:0] audio_out;
  logic                audio_valid;
  logic [ADDR_W:0]     rec_len;
  logic [17:0]         ledr;

  audio_recorder #(
    .CLK_HZ(CLK_HZ), .SAMPLE_RATE(SAMPLE_RATE), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .mic_in(mic_in), .rec_key_n(rec_key_n),
    .play_key_n(play_key_n), .loop_en(loop_en), .audio_out(audio_out),
    .audio_valid(audio_valid), .rec_len(rec_len), .ledr(ledr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: mode 0=idle 1=record 2=play; age = cycles spent in the mode, 1 for the first.
  int          m_mode = 0;
  int          m_age = 0;
  int          m_idx = 0;
  int          m_len = 0;
  logic [15:0] m_buf [DEPTH];
  logic        m_prev_rec = 1'b1;
  logic        m_prev_play = 1'b1;
  logic [15:0] m_mon = '0;
  logic [17:0] m_led = '0;

  always @(posedge clk) begin : model
    logic re, pe, tk;
    int   nmode, nage;
    exp_t e;
    cyc++;
    if (rst) begin
      m_mode = 0; m_age = 0; m_idx = 0; m_len = 0;
      m_prev_rec = 1'b1; m_prev_play = 1'b1;
      m_mon = '0; m_led = '0;
      sb.delete();
    end else begin
      re = m_prev_rec && !rec_key_n;
      pe = m_prev_play && !play_key_n;
      tk = (m_mode != 0) && (m_age % DIV == 0);
      m_led = {m_mode == 1, m_mode == 2,
               (m_mode == 0) ? 16'h0 : 16'((32'h2 << (m_idx >> (ADDR_W - 4))) - 1)};
      m_mon = mic_in;
      m_prev_rec = rec_key_n;
      m_prev_play = play_key_n;
      nmode = m_mode;
      nage = m_age + 1;
      case (m_mode)
        0: begin
          if (re) begin nmode = 1; nage = 1; m_idx = 0; end
          else if (pe && m_len > 0) begin nmode = 2; nage = 1; m_idx = 0; end
        end
        1: begin
          if (tk) begin m_buf[m_idx] = mic_in; m_idx++; end
          if (tk && m_idx == DEPTH) begin m_len = DEPTH; nmode = 0; end
          else if (rec_key_n) begin m_len = m_idx; nmode = 0; end
        end
        default: begin
          if (re) begin nmode = 1; nage = 1; m_idx = 0; end
          else if (pe) begin nage = 1; m_idx = 0; end
          else if (tk) begin
            e.cyc = cyc;
            e.d = m_buf[m_idx];
            sb.push_back(e);
            if (m_idx == m_len - 1) begin
              m_idx = 0;
              if (!loop_en) nmode = 0;
            end else begin
              m_idx++;
            end
          end
        end
      endcase
      m_mode = nmode;
      m_age = nage;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (cyc > 0) begin
      chk("ledr", 32'(ledr), 32'(m_led));
      chk("rec_len", 32'(rec_len), m_len);
      if (audio_valid) begin
        if (sb.size() == 0) begin
          chk("stray_valid", 32'(audio_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sample_time", cyc, e.cyc);
          chk("sample_data", 32'(audio_out), 32'(e.d));
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          chk("missing_valid", 32'(audio_valid), 32'd1);
        end
        if (m_mode != 2) chk("monitor_out", 32'(audio_out), 32'(m_mon));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    mic_in = 16'($urandom);
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic rec_hold(input int n);
    step();
    rec_key_n = 1'b0;
    wait_n(n);
    rec_key_n = 1'b1;
  endtask

  task automatic play_tap();
    step();
    play_key_n = 1'b0;
    step();
    play_key_n = 1'b1;
  endtask

  initial begin
    wait_n(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(audio_valid), 32'd0);
    chk("rst_ledr", 32'(ledr), 32'd0);
    chk("rst_rec_len", 32'(rec_len), 32'd0);
    mic_in = 16'h1234;
    @(negedge clk);
    chk("monitor_1234", 32'(audio_out), 32'h1234);
    mic_in = 16'($urandom);

    // Five-sample take, then one-shot and looped playback.
    rec_hold(22);
    wait_n(2);
    chk("take5_len", 32'(rec_len), 32'd5);
    loop_en = 1'b0;
    play_tap();
    wait_n(30);
    loop_en = 1'b1;
    play_tap();
    wait_n(42);
    loop_en = 1'b0;
    wait_n(30);

    // Hold record past a full buffer.
    rec_hold(80);
    wait_n(2);
    chk("full_len", 32'(rec_len), 32'(DEPTH));

    // Reset during playback, then a play press with nothing recorded.
    play_tap();
    wait_n(9);
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    step();
    chk("rst_mid_play_len", 32'(rec_len), 32'd0);
    play_tap();
    wait_n(10);
    chk("play_empty_ledr", 32'(ledr), 32'd0);

    // Record press aborting a playback.
    rec_hold(14);
    loop_en = 1'b1;
    play_tap();
    wait_n(7);
    rec_hold(10);
    wait_n(3);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: rec_hold($urandom_range(1, 70));
        1: begin play_tap(); wait_n($urandom_range(0, 25)); end
        2: begin loop_en = 1'($urandom); step(); end
        3: wait_n($urandom_range(1, 12));
        default: begin
          step();
          rec_key_n = 1'b0;
          play_key_n = 1'b0;
          step();
          play_key_n = 1'b1;
          wait_n($urandom_range(1, 20));
          rec_key_n = 1'b1;
        end
      endcase
    end

    loop_en = 1'b0;
    wait_n(100);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
